// File: rtl/led_pattern_player.sv
// led_pattern_player
//   Multi-channel LED pattern sequencer. Each channel replays a loadable bit
//   pattern (bit i shown at step i) of programmable length, looping or playing
//   once. A shared prescaler sets the step rate.
// Ports:
//   CLK          system clock (single domain)
//   reset        synchronous, active-high
//   hold         freezes prescaler and all channels
//   load         one-cycle strobe writing channel load_ch (out-of-range ignored)
//   load_pattern pattern bits, load_len step count (0 = idle, clamped to PAT_LEN)
//   load_oneshot 1 = play once then stop, 0 = loop
//   led          registered LED outputs, busy = channel playing,
//   done         one-cycle pulse when a one-shot channel finishes

// Per-channel state and step logic.
module led_pattern_channel #(
  parameter int               PAT_LEN    = 32,
  parameter int               LW         = 6,
  parameter int               IW         = 5,
  parameter logic [PAT_LEN-1:0] RST_PAT  = '0,
  parameter int               RST_LEN    = 0,
  parameter bit               RST_ACTIVE = 1'b0
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               tick,
  input  logic               ld,
  input  logic [PAT_LEN-1:0] ld_pattern,
  input  logic [LW-1:0]      ld_len,
  input  logic               ld_oneshot,
  output logic               led,
  output logic               busy,
  output logic               done
);
  logic [PAT_LEN-1:0] pat, pat_n;
  logic [LW-1:0]      len, len_n, len_clamp, idx_inc;
  logic [IW-1:0]      idx, idx_n;
  logic               oneshot, oneshot_n, active, active_n, done_n, led_n;

  always_comb begin
    pat_n     = pat;
    len_n     = len;
    oneshot_n = oneshot;
    idx_n     = idx;
    active_n  = active;
    done_n    = 1'b0;
    len_clamp = (ld_len > LW'(PAT_LEN)) ? LW'(PAT_LEN) : ld_len;
    // idx+1 < len avoids the len-1 underflow when len is 0
    idx_inc   = LW'(idx) + LW'(1);
    if (ld) begin
      // a load on a tick edge wins: restart at bit 0, no step, no done
      pat_n     = ld_pattern;
      len_n     = len_clamp;
      oneshot_n = ld_oneshot;
      idx_n     = '0;
      active_n  = (len_clamp != '0);
    end else if (tick && active) begin
      if (idx_inc < len) begin
        idx_n = idx + IW'(1);
      end else if (!oneshot) begin
        idx_n = '0;
      end else begin
        idx_n    = '0;
        active_n = 1'b0;
        done_n   = 1'b1;
      end
    end
    // LED reflects the next step on the same edge idx changes
    led_n = active_n & pat_n[idx_n];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      pat     <= RST_PAT;
      len     <= LW'(RST_LEN);
      oneshot <= 1'b0;
      idx     <= '0;
      active  <= RST_ACTIVE;
      led     <= RST_ACTIVE & RST_PAT[0];
      done    <= 1'b0;
    end else begin
      pat     <= pat_n;
      len     <= len_n;
      oneshot <= oneshot_n;
      idx     <= idx_n;
      active  <= active_n;
      led     <= led_n;
      done    <= done_n;
    end
  end

  assign busy = active;
endmodule

module led_pattern_player #(
  parameter int                 CHANNELS      = 1,
  parameter int                 PAT_LEN       = 32,
  parameter int                 STEP_CYCLES   = 2097152,
  parameter logic [PAT_LEN-1:0] RESET_PATTERN = 'h0547_7715,
  parameter int                 RESET_LEN     = 32,
  localparam int                CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int                LW = $clog2(PAT_LEN + 1)
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                hold,
  input  logic                load,
  input  logic [CW-1:0]       load_ch,
  input  logic [PAT_LEN-1:0]  load_pattern,
  input  logic [LW-1:0]       load_len,
  input  logic                load_oneshot,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);
  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  logic [PW-1:0] count;
  logic          last, tick;

  assign last = (count == PW'(STEP_CYCLES - 1));
  assign tick = last && !hold;

  // Free-running prescaler; loads do not disturb its phase.
  always_ff @(posedge CLK) begin
    if (reset)      count <= '0;
    else if (!hold) count <= last ? '0 : count + PW'(1);
  end

  // load_ch values past CHANNELS-1 match no instance and are dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    led_pattern_channel #(
      .PAT_LEN   (PAT_LEN),
      .LW        (LW),
      .IW        (IW),
      .RST_PAT   ((g == 0) ? RESET_PATTERN : '0),
      .RST_LEN   ((g == 0) ? RESET_LEN : 0),
      .RST_ACTIVE(g == 0)
    ) u_ch (
      .CLK       (CLK),
      .reset     (reset),
      .tick      (tick),
      .ld        (load && (load_ch == CW'(g))),
      .ld_pattern(load_pattern),
      .ld_len    (load_len),
      .ld_oneshot(load_oneshot),
      .led       (led[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end
endmodule

// File: tb/tb_led_pattern_player.sv
module tb_led_pattern_player;
  logic        CLK = 1'b0;
  logic        reset = 1'b1, hold = 1'b0, load = 1'b0, load_oneshot = 1'b0;
  logic [1:0]  load_ch = '0;
  logic [31:0] load_pattern = '0;
  logic [5:0]  load_len = '0;
  logic [2:0]  led, busy, done;

  led_pattern_player #(.CHANNELS(3), .STEP_CYCLES(4)) dut (
    .CLK(CLK), .reset(reset), .hold(hold), .load(load), .load_ch(load_ch),
    .load_pattern(load_pattern), .load_len(load_len), .load_oneshot(load_oneshot),
    .led(led), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;  // number of rising edges so far
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      nm;
    logic [2:0] m, led, busy, done;
  } exp_t;
  exp_t sb[$];
  int   n_cmp = 0, n_err = 0;
  logic flush = 1'b0;

  // Expected state after rising edge 'at', checked on the following falling edge.
  task automatic push(input int at, input string nm, input logic [2:0] m,
                      input logic [2:0] l, input logic [2:0] b, input logic [2:0] d);
    exp_t e;
    e.at = at; e.nm = nm; e.m = m; e.led = l; e.busy = b; e.done = d;
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (flush || sb[i].at <= cyc) begin
        n_cmp++;
        if (flush || sb[i].at != cyc) begin
          n_err++;
          $display("FAIL %s: entry for edge %0d never sampled (now %0d)", sb[i].nm, sb[i].at, cyc);
        end else if ((((led ^ sb[i].led) | (busy ^ sb[i].busy) | (done ^ sb[i].done)) & sb[i].m) !== 3'b000) begin
          n_err++;
          $display("FAIL %s @edge %0d: led=%b busy=%b done=%b, expected led=%b busy=%b done=%b (mask %b)",
                   sb[i].nm, cyc, led, busy, done, sb[i].led, sb[i].busy, sb[i].done, sb[i].m);
        end
        sb.delete(i);
      end
    end
  end

  // Return 1 time unit after rising edge n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Present a load so it is captured on rising edge 'at'.
  task automatic do_load(input int at, input int ch, input logic [31:0] pat,
                         input int len, input bit os);
    goto(at - 1);
    load = 1'b1; load_ch = 2'(ch); load_pattern = pat;
    load_len = 6'(len); load_oneshot = os;
    goto(at);
    load = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached at edge %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rp;
    rp = 32'h0547_7715;

    // Reset default: ticks on edges 6,10,... ; ch0 walks the SOS pattern
    goto(2);
    reset = 1'b0;
    push(2, "reset_state", 3'b111, 3'b001, 3'b001, 3'b000);
    for (int k = 1; k <= 32; k++) begin
      push(2 + 4*k, "sos_tick", 3'b111, {2'b00, rp[k % 32]}, 3'b001, 3'b000);
      push(1 + 4*k, "sos_pre_tick", 3'b111, {2'b00, rp[(k - 1) % 32]}, 3'b001, 3'b000);
    end

    // One-shot 0b1101 len 4 on ch0, loaded at edge 132; ticks 134,138,142,146
    push(132, "os_load", 3'b111, 3'b001, 3'b001, 3'b000);
    push(133, "os_step0", 3'b111, 3'b001, 3'b001, 3'b000);
    push(134, "os_step1", 3'b001, 3'b000, 3'b001, 3'b000);
    push(138, "os_step2", 3'b001, 3'b001, 3'b001, 3'b000);
    push(145, "os_step3", 3'b111, 3'b001, 3'b001, 3'b000);
    push(146, "os_finish", 3'b111, 3'b000, 3'b000, 3'b001);
    push(147, "os_done_1cyc", 3'b111, 3'b000, 3'b000, 3'b000);
    push(160, "os_stays_off", 3'b111, 3'b000, 3'b000, 3'b000);
    do_load(132, 0, 32'b1101, 4, 1'b1);

    // Multi-channel: ch0 0b011/3, ch2 0b10/2 loop; ch1 loaded on tick edge 174
    push(173, "mc_before", 3'b111, 3'b000, 3'b101, 3'b000);
    push(174, "mc_load_on_tick", 3'b111, 3'b111, 3'b111, 3'b000);
    push(177, "mc_hold_step", 3'b111, 3'b111, 3'b111, 3'b000);
    push(178, "mc_step_a", 3'b111, 3'b001, 3'b111, 3'b000);
    push(182, "mc_step_b", 3'b111, 3'b110, 3'b111, 3'b000);
    do_load(164, 0, 32'b011, 3, 1'b0);
    do_load(165, 2, 32'b10, 2, 1'b0);
    do_load(174, 1, 32'b101, 3, 1'b0);

    // len 0 on ch2 goes idle even with an all-ones pattern
    push(184, "len0_idle", 3'b111, 3'b010, 3'b011, 3'b000);
    push(186, "len0_ignores_tick", 3'b111, 3'b011, 3'b011, 3'b000);
    do_load(184, 2, 32'hFFFF_FFFF, 0, 1'b0);

    // len 63 on ch2 clamps to 32: bits 0 and 31 set, tick k lands on edge 186+4k
    push(188, "clamp_load", 3'b100, 3'b100, 3'b100, 3'b000);
    push(190, "clamp_step1", 3'b100, 3'b000, 3'b100, 3'b000);
    push(309, "clamp_step30", 3'b100, 3'b000, 3'b100, 3'b000);
    push(310, "clamp_step31", 3'b100, 3'b100, 3'b100, 3'b000);
    push(314, "clamp_wrap", 3'b100, 3'b100, 3'b100, 3'b000);
    push(318, "clamp_step1b", 3'b100, 3'b000, 3'b100, 3'b000);
    do_load(188, 2, 32'h8000_0001, 63, 1'b0);

    // len 1 loop on ch1 holds pat[0]
    push(320, "len1_load", 3'b010, 3'b010, 3'b010, 3'b000);
    push(322, "len1_tick_a", 3'b010, 3'b010, 3'b010, 3'b000);
    push(330, "len1_tick_b", 3'b010, 3'b010, 3'b010, 3'b000);
    do_load(320, 1, 32'h3, 1, 1'b0);

    // hold: ch0 0b0101/4 loaded at 332, tick 334; hold edges 336..345 -> next tick 348
    push(334, "hold_pre", 3'b001, 3'b000, 3'b001, 3'b000);
    push(338, "hold_no_tick", 3'b001, 3'b000, 3'b001, 3'b000);
    push(345, "hold_frozen", 3'b001, 3'b000, 3'b001, 3'b000);
    push(347, "hold_resume", 3'b001, 3'b000, 3'b001, 3'b000);
    push(348, "hold_tick", 3'b001, 3'b001, 3'b001, 3'b000);
    do_load(332, 0, 32'h5, 4, 1'b0);
    goto(335);
    hold = 1'b1;
    goto(345);
    hold = 1'b0;

    // Reset during a one-shot on ch1 (loaded 350, ticks 352,356); reset at edge 357
    push(356, "rst_mid_busy", 3'b010, 3'b010, 3'b010, 3'b000);
    push(357, "rst_mid", 3'b111, 3'b001, 3'b001, 3'b000);
    push(360, "rst_pre_tick", 3'b111, 3'b001, 3'b001, 3'b000);
    push(361, "rst_first_tick", 3'b111, 3'b000, 3'b001, 3'b000);
    push(364, "rst_no_done", 3'b111, 3'b000, 3'b001, 3'b000);
    do_load(350, 1, 32'hF, 4, 1'b1);
    goto(356);
    reset = 1'b1;
    goto(357);
    reset = 1'b0;

    goto(370);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/led_pattern_player.md
# led_pattern_player

Parametrised multi-channel LED pattern sequencer, the successor to the hard-wired SOS blinker in the board top level. Each channel replays a runtime-loadable bit pattern of programmable length, one bit per step, in loop or one-shot mode. A shared prescaler derived from `CLK` sets the step rate. The block sits in `top` and drives `LED` plus any spare status pins, and the CPU or boot logic can reload patterns while running.

## Interface
- `CHANNELS`, 1 — number of independent LED channels (1..16)
- `PAT_LEN`, 32 — maximum pattern length in steps (bits)
- `STEP_CYCLES`, 2097152 — `CLK` cycles per step (≥1); the default gives ≈131 ms at 16 MHz
- `RESET_PATTERN`, 32'h0547_7715 — channel 0 pattern after reset (SOS, LSB first)
- `RESET_LEN`, 32 — channel 0 length after reset (≤ `PAT_LEN`)
- `CLK` in 1 — 16 MHz system clock; single clock domain
- `reset` in 1 — synchronous, active-high reset
- `hold` in 1 — freezes the prescaler and all channels while high
- `load` in 1 — single-cycle strobe that writes one channel
- `load_ch` in clog2(CHANNELS) (min 1) — target channel; an out-of-range value means `load` is ignored
- `load_pattern` in PAT_LEN — pattern; bit i is shown at step i
- `load_len` in clog2(PAT_LEN+1) — number of steps; 0 means the channel goes idle
- `load_oneshot` in 1 — 1 selects play once then stop, 0 selects loop
- `led` out CHANNELS — registered LED outputs
- `busy` out CHANNELS — channel is active (playing)
- `done` out CHANNELS — one-cycle pulse when a one-shot channel finishes

## Operation
- Each channel holds state registers `pat`, `len`, `oneshot`, `idx`, `active`.
- Prescaler: counts 0..STEP_CYCLES-1 and wraps. `tick` is asserted when `count == STEP_CYCLES-1` and `hold` is 0. While `hold` is 1, the count does not advance.
- On `tick`, every active channel advances:
  - If `idx < len-1`: `idx++`.
  - Else, in loop mode: `idx <= 0`.
  - Else, in one-shot mode: `active <= 0`, `idx <= 0`, `done[ch]` pulses.
- Inactive channels ignore `tick`.
- `led[ch]` is registered and updated on every edge to `active_next & pat_next[idx_next]`. The LED therefore shows the new step on the same edge that `idx` changes.
- `busy[ch] = active[ch]`, registered.
- Load: on the edge where `load` is high and `load_ch` is valid, the target channel gets:
  - `pat`, `oneshot`, and `idx <= 0`.
  - `len <= min(load_len, PAT_LEN)`.
  - `active <= (len != 0)`.
  - `led[ch] <= active_next & load_pattern[0]` on the same edge.
- Load does not reset the prescaler. The first step after a load therefore lasts 1..STEP_CYCLES cycles.
- Load to a channel on the same edge as a tick: load wins, that channel does not step, and no `done` pulse is issued. Other channels step normally.
- Load while `hold` is high is accepted. The channel shows bit 0 and stays frozen until `hold` drops.
- Reloading an active channel restarts it immediately with no glitch cycle.
- `len == 1` in loop mode gives a constant output of `pat[0]`.
- A one-shot channel with `len == 1` finishes on the first tick after the load.

## Timing
- Reset (synchronous, one edge with `reset` high):
  - Prescaler is 0.
  - Channel 0: `pat=RESET_PATTERN`, `len=RESET_LEN`, loop mode, `active=1`, `idx=0`.
  - Channels 1..CHANNELS-1: `pat=0`, `len=0`, `active=0`.
- Output reset values:
  - `led = {0…, RESET_PATTERN[0]}`.
  - `busy = {0…, 1}`.
  - `done = 0`.
- `reset` overrides `load` and `hold`. A reset mid-pattern returns every channel to the state above on that edge.
- First tick after reset falls on the STEP_CYCLES-th rising edge after reset is released.
- Load to `led` latency: 1 edge.
- Tick to `led` latency: 0 extra; `led` changes on the tick edge.
- `done` is high for exactly one cycle, on the tick edge where `active` falls. `busy` falls on the same edge.
- A full loop period is `len × STEP_CYCLES` cycles. Wrap from `idx=len-1` to 0 takes no extra cycle.

## Test plan
- **Reset default (STEP_CYCLES=4, defaults otherwise).**
  - Stimulus: release `reset`, sample `led[0]` at every tick.
  - Required: `led[0]` follows 0x05477715 LSB-first: 1,0,1,0,1,0,0,0,1,1,1,0…. After 32 ticks it returns to bit 0. `busy=1`, `done` is never asserted.
- **One-shot (STEP_CYCLES=4).**
  - Stimulus: load ch0 with `pattern=0b1101`, `len=4`, `oneshot=1`.
  - Required: `led` reads 1, 0, 1, 1 across steps.
  - Required: on the 4th tick `led=0`, `busy` falls and `done` pulses for exactly 1 cycle.
  - Required: no further changes afterwards.
- **Multi-channel, simultaneous load and tick (CHANNELS=3).**
  - Stimulus: load ch1 on the exact tick edge while ch0 and ch2 loop.
  - Required: ch1 shows `load_pattern[0]` with `idx=0`; ch0 and ch2 advance by one step.
- **Boundary lengths.**
  - Stimulus: `load_len=0`. Required: `busy=0`, `led=0`.
  - Stimulus: `load_len=PAT_LEN+…` (max encodable). Required: clamped to 32 steps, wrap after step 31.
  - Stimulus: `len=1` loop with `pattern[0]=1`. Required: `led` held at 1.
- **hold.**
  - Stimulus: assert `hold` for 10 cycles mid-pattern.
  - Required: `idx`, `led` and the prescaler are frozen. After `hold` drops, the remaining cycles of the current step complete unchanged.
- **Reset mid-operation.**
  - Stimulus: assert `reset` during a one-shot on ch1.
  - Required: on the next edge ch1 is idle with `led[1]=0`, ch0 is back to `RESET_PATTERN` at `idx=0`, and `done=0`.
